// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_pkg
//  Description : Shared constants and types for the universal shift register.
//                - Immediate mode encodings for the 's' input
//                - Multi-cycle shift kind encodings for the 'kind' input
//                - Sequencer state type
//  Revision    : 1.0  initial release
// ============================================================================
package shift_reg_pkg;

    // Immediate modes, applied when the sequencer is idle and no start is seen
    localparam logic [1:0] HOLD    = 2'b00;
    localparam logic [1:0] SHR     = 2'b01;
    localparam logic [1:0] SHL     = 2'b10;
    localparam logic [1:0] LOAD    = 2'b11;

    // Fill behaviour of a single-bit step
    localparam logic [1:0] LOGICAL = 2'b00;
    localparam logic [1:0] ARITH   = 2'b01;
    localparam logic [1:0] ROTATE  = 2'b10;
    localparam logic [1:0] SERIAL  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_reg_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_step
//  Description : Combinational single-bit shift step. Computes the next
//                register value and the bit that falls off the end for one
//                step in the given direction with the given fill kind.
//  Ports       : i_q      current register value
//                i_dir    0 = right, 1 = left
//                i_kind   fill kind (logical / arithmetic / rotate / serial)
//                i_sir    serial fill for right steps (enters the MSB)
//                i_sil    serial fill for left steps (enters the LSB)
//                o_q_next register value after the step
//                o_bit    bit shifted out (LSB for right, MSB for left)
//  Revision    : 1.0  initial release
// ============================================================================
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_dir,
    input  logic [1:0]       i_kind,
    input  logic             i_sir,
    input  logic             i_sil,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_bit
);

    logic w_fill_r;
    logic w_fill_l;

    always_comb begin
        w_fill_r = 1'b0;
        w_fill_l = 1'b0;
        case (i_kind)
            LOGICAL: begin
                w_fill_r = 1'b0;
                w_fill_l = 1'b0;
            end
            ARITH: begin
                // Sign extension only makes sense going right
                w_fill_r = i_q[WIDTH-1];
                w_fill_l = 1'b0;
            end
            ROTATE: begin
                w_fill_r = i_q[0];
                w_fill_l = i_q[WIDTH-1];
            end
            SERIAL: begin
                w_fill_r = i_sir;
                w_fill_l = i_sil;
            end
            default: begin
                w_fill_r = 1'b0;
                w_fill_l = 1'b0;
            end
        endcase
    end

    always_comb begin
        if (i_dir) begin
            o_q_next = {i_q[WIDTH-2:0], w_fill_l};
            o_bit    = i_q[WIDTH-1];
        end else begin
            o_q_next = {w_fill_r, i_q[WIDTH-1:1]};
            o_bit    = i_q[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg_seq
//  Description : Parametrised universal shift register with single-cycle
//                hold / shift right / shift left / parallel load, plus a
//                multi-cycle shift engine (logical, arithmetic, rotate or
//                serial fill) driven by a start/busy/done handshake.
//  Options     : SHIFT_REG_CARRY_EN - when defined, adds carry_out holding the
//                last bit shifted out by any step.
//  Ports       : clk        system clock, rising edge
//                clear      synchronous active-high reset
//                s          immediate mode when idle (hold/shr/shl/load)
//                p          parallel load data
//                sir / sil  serial inputs for right / left steps
//                start      request a multi-cycle shift (sampled when idle)
//                dir        multi-cycle direction (0 right, 1 left)
//                kind       multi-cycle fill kind
//                amount     number of single-bit steps
//                q          register contents
//                busy       multi-cycle shift in progress
//                done       one-cycle pulse when a multi-cycle shift ends
//                carry_out  last shifted-out bit (SHIFT_REG_CARRY_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
module univ_shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] p,
    input  logic             sir,
    input  logic             sil,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       kind,
    input  logic [AMT_W-1:0] amount,
`ifdef SHIFT_REG_CARRY_EN
    output logic             carry_out,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [AMT_W-1:0] r_cnt;
    logic             r_dir;
    logic [1:0]       r_kind;
    logic             r_done;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_q_next;
    logic [AMT_W-1:0] w_cnt_next;
    logic             w_dir_next;
    logic [1:0]       w_kind_next;
    logic             w_done_next;

    // Shared step datapath
    logic             w_step_dir;
    logic [1:0]       w_step_kind;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_bit;

`ifdef SHIFT_REG_CARRY_EN
    logic             r_carry;
    logic             w_carry_next;
`endif

    // While shifting, the latched direction/kind drive the step; when idle the
    // immediate modes always use serial fill, with direction taken from s.
    always_comb begin
        if (r_state == SHIFT) begin
            w_step_dir  = r_dir;
            w_step_kind = r_kind;
        end else begin
            w_step_dir  = (s == SHL);
            w_step_kind = SERIAL;
        end
    end

    shift_reg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q      (r_q),
        .i_dir    (w_step_dir),
        .i_kind   (w_step_kind),
        .i_sir    (sir),
        .i_sil    (sil),
        .o_q_next (w_step_q),
        .o_bit    (w_step_bit)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;
        w_kind_next  = r_kind;
        w_done_next  = 1'b0;
`ifdef SHIFT_REG_CARRY_EN
        w_carry_next = r_carry;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_dir_next  = dir;
                    w_kind_next = kind;
                    w_cnt_next  = amount;
                    // A zero-length request completes immediately without
                    // ever asserting busy.
                    if (amount == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = SHIFT;
                    end
                end else begin
                    case (s)
                        HOLD: begin
                            w_q_next = r_q;
                        end
                        SHR, SHL: begin
                            w_q_next = w_step_q;
`ifdef SHIFT_REG_CARRY_EN
                            w_carry_next = w_step_bit;
`endif
                        end
                        LOAD: begin
                            w_q_next = p;
                        end
                        default: begin
                            w_q_next = r_q;
                        end
                    endcase
                end
            end
            SHIFT: begin
                w_q_next   = w_step_q;
                w_cnt_next = r_cnt - AMT_W'(1);
`ifdef SHIFT_REG_CARRY_EN
                w_carry_next = w_step_bit;
`endif
                if (r_cnt == AMT_W'(1)) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_kind  <= LOGICAL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_cnt   <= w_cnt_next;
            r_dir   <= w_dir_next;
            r_kind  <= w_kind_next;
            r_done  <= w_done_next;
        end
    end

`ifdef SHIFT_REG_CARRY_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            r_carry <= 1'b0;
        end else begin
            r_carry <= w_carry_next;
        end
    end

    assign carry_out = r_carry;
`endif

    assign q    = r_q;
    assign busy = (r_state == SHIFT);
    assign done = r_done;

endmodule
`default_nettype wire

// File: doc/univ_shift_reg_seq.md
Name: univ_shift_reg_seq

Overview:
Parametrised successor to the 4-bit universal shift register. Keeps the single-cycle hold, shift-right, shift-left and parallel-load modes, at any width. Adds a multi-cycle shift engine (logical, arithmetic, rotate or serial-fill) that runs N single-bit steps with a start/busy/done handshake. Sits in the datapath as the shifter/serialiser for ALU shift instructions and for serial I/O.

Parameters:
WIDTH, 8, register width in bits (≥2)
AMT_W, $clog2(WIDTH)+1, width of the shift-amount input (derived; not overridden)

Ports:
clk  in  1  system clock; all state changes on the rising edge
clear  in  1  synchronous, active-high reset
s  in  2  immediate mode when idle: 00 hold, 01 shift right, 10 shift left, 11 parallel load
p  in  WIDTH  parallel load data
sir  in  1  serial input for shift right (enters q[WIDTH-1])
sil  in  1  serial input for shift left (enters q[0])
start  in  1  request a multi-cycle shift; sampled only when idle
dir  in  1  multi-cycle direction: 0 right, 1 left
kind  in  2  multi-cycle kind: 00 logical, 01 arithmetic, 10 rotate, 11 serial
amount  in  AMT_W  number of single-bit steps
q  out  WIDTH  register contents
busy  out  1  multi-cycle shift in progress
done  out  1  one-cycle pulse: multi-cycle shift finished

Behaviour:
- Clock and reset: one clock (clk). Reset (clear) is synchronous and active-high.
- Reset: when clear=1 at an edge, q=0, busy=0, done=0 and state=IDLE. Clear overrides every other input, including a shift already in progress. Any abort of a running shift produces no done pulse.
- Step definitions:
  - right: q <= {fill_r, q[WIDTH-1:1]}
  - left: q <= {q[WIDTH-2:0], fill_l}
- Fill per kind:
  - logical: fill_r = 0, fill_l = 0
  - arithmetic: fill_r = q[WIDTH-1], fill_l = 0
  - rotate: fill_r = q[0], fill_l = q[WIDTH-1]
  - serial: fill_r = sir, fill_l = sil
- Immediate s=01 and s=10 always use serial fill.
- FSM states: IDLE, SHIFT.
- IDLE with start=0: apply s on this edge. Single-cycle latency; done stays 0.
- IDLE with start=1: start takes priority and s is ignored. Latch dir and kind, and set cnt = amount.
  - amount=0: stay in IDLE, q unchanged, done=1 on the next cycle.
  - otherwise: go to SHIFT.
- SHIFT: each edge performs one step using the latched dir and kind, and decrements cnt. When cnt==1, go to IDLE and set done=1 for the following cycle.
- busy = (state==SHIFT) and is registered. For amount=N (N>0): busy is high for exactly N cycles, q changes on N edges, and done is high in the first cycle after busy falls, together with the final q.
- While busy, s, p, start, dir, kind and amount are ignored. sir/sil are still sampled live for kind=serial.
- amount > WIDTH is legal: steps are executed literally. Rotate wraps around; logical shifts saturate to all fill.
- done and a new start may coincide. The new start is accepted because the FSM is in IDLE.

Optional Feature:
Macro SHIFT_REG_CARRY_EN.
- Defined: adds output carry_out (1 bit, reset 0). It holds the last bit shifted out by any step, immediate or multi-cycle: q[0] for right, q[WIDTH-1] for left. Load, hold and amount=0 leave it unchanged.
- Undefined: the port and its register do not exist.

Decomposition:
- Package shift_reg_pkg:
  - mode constants for s (HOLD, SHR, SHL, LOAD)
  - kind constants (LOGICAL, ARITH, ROTATE, SERIAL)
  - FSM state typedef (IDLE, SHIFT)
- One combinational sub-module, shift_reg_step. Inputs: q, dir, kind, sir, sil. Outputs: the next q and the shifted-out bit. It is used by both the immediate path and the multi-cycle path.

Test Plan:
All scenarios use WIDTH=8.
- q=0xA5, then clear=1 for one edge -> q=0x00, busy=0, done=0. Reset also works while s=11.
- s=11, p=0xA5 -> q=0xA5 after 1 edge. Then s=01, sir=1 -> q=0xD2. Then s=10, sil=0 -> q=0xA4. done stays 0 throughout.
- q=0x96, start with dir=0, kind=01, amount=3 -> busy high for 3 cycles, q=0xF2, done high for exactly 1 cycle. Pulsing start again mid-run is ignored.
- q=0xA5, start with dir=1, kind=10, amount=4 -> q=0x5A. With amount=8, q returns to 0xA5. With amount=0, done is high on the next cycle, busy never rises and q is unchanged.
- q=0xFF, logical right with amount=5; assert clear after 2 steps -> q=0x00, busy=0, no done. A start on the next cycle is accepted normally.
- With SHIFT_REG_CARRY_EN defined: q=0xA5, logical right by 1 -> q=0x52, carry_out=1. Then rotate left by 1 -> q=0xA4, carry_out=0.
